// File: rtl/csd_twiddle_mult.sv
// Multi-lane complex multiply by W8^k, k = 0..3, in a 3-stage pipeline.
// Multiplication by 1/sqrt2 (724/1024) is a shift-add network, so no multiplier is used.

module csd_twiddle_lane #(
    parameter int NB_INPUT  = 23,
    parameter int NB_OUTPUT = NB_INPUT + 11
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [1:0]           sel,
    input  logic [NB_INPUT-1:0]  re,
    input  logic [NB_INPUT-1:0]  im,
    output logic [NB_OUTPUT-1:0] o_re,
    output logic [NB_OUTPUT-1:0] o_im
);
    localparam int NB_PRE = NB_INPUT + 1;

    // 724 = 2^10 - 2^8 - 2^6 + 2^4 + 2^2 (non-adjacent signed digits)
    function automatic logic signed [NB_OUTPUT-1:0] mul_c(input logic signed [NB_OUTPUT-1:0] x);
        return (x <<< 10) - (x <<< 8) - (x <<< 6) + (x <<< 4) + (x <<< 2);
    endfunction

    // S1: input capture
    logic signed [NB_INPUT-1:0] a_q, b_q;
    logic        [1:0]          k_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            k_q <= '0;
        end else if (en) begin
            a_q <= re;
            b_q <= im;
            k_q <= sel;
        end
    end

    // S2: pre-add at full width, then pick operands per k
    logic signed [NB_PRE-1:0] a_x, b_x, sum, dif;
    logic signed [NB_PRE-1:0] op_re_d, op_im_d, op_re_q, op_im_q;
    logic                     use_c_d, neg_d, use_c_q, neg_q;

    assign a_x = a_q;
    assign b_x = b_q;
    assign sum = a_x + b_x;
    assign dif = b_x - a_x;

    always_comb begin
        op_re_d = a_x;
        op_im_d = b_x;
        use_c_d = 1'b0;
        neg_d   = 1'b0;
        case (k_q)
            2'd1: begin op_re_d = sum; op_im_d = dif; use_c_d = 1'b1; end
            2'd2: begin op_re_d = b_x; op_im_d = a_x; neg_d = 1'b1; end
            2'd3: begin op_re_d = dif; op_im_d = sum; use_c_d = 1'b1; neg_d = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_re_q <= '0;
            op_im_q <= '0;
            use_c_q <= 1'b0;
            neg_q   <= 1'b0;
        end else if (en) begin
            op_re_q <= op_re_d;
            op_im_q <= op_im_d;
            use_c_q <= use_c_d;
            neg_q   <= neg_d;
        end
    end

    // S3: scale by C or by 2^10, negate imaginary for k = 2, 3
    logic signed [NB_OUTPUT-1:0] x_re, x_im, p_re, p_im;

    assign x_re = op_re_q;
    assign x_im = op_im_q;
    assign p_re = use_c_q ? mul_c(x_re) : (x_re <<< 10);
    assign p_im = use_c_q ? mul_c(x_im) : (x_im <<< 10);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_re <= '0;
            o_im <= '0;
        end else if (en) begin
            o_re <= p_re;
            o_im <= neg_q ? -p_im : p_im;
        end
    end
endmodule

module csd_twiddle_mult #(
    parameter int NB_INPUT  = 23,
    parameter int NB_OUTPUT = NB_INPUT + 11,
    parameter int N_LANES   = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_en,
    input  logic                         i_valid,
    input  logic [2*N_LANES-1:0]         i_sel,
    input  logic [NB_INPUT*N_LANES-1:0]  i_re,
    input  logic [NB_INPUT*N_LANES-1:0]  i_im,
    output logic                         o_valid,
    output logic [NB_OUTPUT*N_LANES-1:0] o_re,
    output logic [NB_OUTPUT*N_LANES-1:0] o_im
);
    localparam int STAGES = 3;

    logic [STAGES:1] vld_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    vld_pipe <= '0;
        else if (i_en) vld_pipe <= {vld_pipe[STAGES-1:1], i_valid};
    end

    assign o_valid = vld_pipe[STAGES];

    // Instance array splits the flat buses; lane 0 takes the LSB slice.
    csd_twiddle_lane #(
        .NB_INPUT (NB_INPUT),
        .NB_OUTPUT(NB_OUTPUT)
    ) u_lane [N_LANES-1:0] (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (i_en),
        .sel  (i_sel),
        .re   (i_re),
        .im   (i_im),
        .o_re (o_re),
        .o_im (o_im)
    );
endmodule

// File: tb/tb_csd_twiddle_mult.sv
// Scoreboard bench for csd_twiddle_mult: directed scenarios, stall, mid-stream reset, random.
module tb_csd_twiddle_mult;
    localparam int NBI = 23;
    localparam int NBO = NBI + 11;
    localparam int NL  = 4;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    i_en = 1'b0;
    logic                    i_valid = 1'b0;
    logic [NL-1:0][1:0]      i_sel = '0;
    logic [NL-1:0][NBI-1:0]  i_re = '0;
    logic [NL-1:0][NBI-1:0]  i_im = '0;
    logic                    o_valid;
    logic [NL-1:0][NBO-1:0]  o_re, o_im;

    csd_twiddle_mult #(.NB_INPUT(NBI), .NB_OUTPUT(NBO), .N_LANES(NL)) dut (
        .clk(clk), .rst_n(rst_n), .i_en(i_en), .i_valid(i_valid), .i_sel(i_sel),
        .i_re(i_re), .i_im(i_im), .o_valid(o_valid), .o_re(o_re), .o_im(o_im)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NL-1:0][63:0] re;
        logic [NL-1:0][63:0] im;
        int                  tag;
    } exp_t;

    exp_t                   sb[$];
    int                     n_chk = 0;
    int                     n_fail = 0;
    int                     en_cnt = 0;
    bit                     en_last = 1'b0;
    logic                   prev_v = 1'b0;
    logic [NL-1:0][NBO-1:0] prev_re = '0, prev_im = '0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic longint gold(input longint a, input longint b, input logic [1:0] k, input bit want_im);
        case (k)
            2'd0:    return want_im ? b * 1024 : a * 1024;
            2'd1:    return want_im ? (b - a) * 724 : (a + b) * 724;
            2'd2:    return want_im ? -a * 1024 : b * 1024;
            default: return want_im ? -(a + b) * 724 : (b - a) * 724;
        endcase
    endfunction

    // Called at a rising edge; drives inputs for the next one and books the capture.
    task automatic drive(input bit v, input bit e, input logic [NL-1:0][1:0] k,
                         input logic [NL-1:0][NBI-1:0] a, input logic [NL-1:0][NBI-1:0] b);
        exp_t x;
        #1;
        i_valid = v; i_en = e; i_sel = k; i_re = a; i_im = b;
        for (int l = 0; l < NL; l++) begin
            x.re[l] = gold(longint'($signed(a[l])), longint'($signed(b[l])), k[l], 1'b0);
            x.im[l] = gold(longint'($signed(a[l])), longint'($signed(b[l])), k[l], 1'b1);
        end
        x.tag = en_cnt;
        @(posedge clk);
        en_last = e && rst_n;
        if (e && rst_n) begin
            en_cnt++;
            if (v) sb.push_back(x);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b1, '0, '0, '0);
    endtask

    function automatic logic [NBI-1:0] rnd_val();
        case ($urandom_range(0, 7))
            0:       return {1'b1, {(NBI-1){1'b0}}};
            1:       return {1'b0, {(NBI-1){1'b1}}};
            2:       return '0;
            3:       return '1;
            default: return NBI'($urandom);
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_v = 1'b0; prev_re = '0; prev_im = '0;
        end else begin
            if (!en_last) begin
                chk("stall_valid_hold", o_valid, prev_v);
                chk("stall_re_hold", (o_re == prev_re), 1);
                chk("stall_im_hold", (o_im == prev_im), 1);
            end else if (o_valid) begin
                if (sb.size() == 0) chk("spurious_valid", o_valid, 0);
                else begin
                    e = sb.pop_front();
                    chk("latency", en_cnt, e.tag + 3);
                    for (int l = 0; l < NL; l++) begin
                        chk($sformatf("re_l%0d", l), longint'($signed(o_re[l])), longint'($signed(e.re[l])));
                        chk($sformatf("im_l%0d", l), longint'($signed(o_im[l])), longint'($signed(e.im[l])));
                    end
                end
            end
            prev_v = o_valid; prev_re = o_re; prev_im = o_im;
        end
    end

    initial begin
        logic [NL-1:0][1:0]     k;
        logic [NL-1:0][NBI-1:0] a, b;
        bit                     v, e;

        // Reset state, then release away from the rising edge
        #3;
        chk("rst_valid", o_valid, 0);
        chk("rst_re", |o_re, 0);
        chk("rst_im", |o_im, 0);
        @(negedge clk); #2 rst_n = 1'b1;

        // Single lane, k=1: expect (72400, -72400)
        k = '0; a = '0; b = '0;
        k[0] = 2'd1; a[0] = NBI'(100);
        drive(1'b1, 1'b1, k, a, b);

        // One vector, lanes k=0..3, a=5, b=-3
        for (int l = 0; l < NL; l++) begin
            k[l] = 2'(l); a[l] = NBI'(5); b[l] = NBI'(-3);
        end
        drive(1'b1, 1'b1, k, a, b);

        // Most-negative input extremes
        k = '0; a = '0; b = '0;
        k[0] = 2'd3; a[0] = NBI'(-4194304); b[0] = NBI'(-4194304);
        drive(1'b1, 1'b1, k, a, b);
        k[0] = 2'd2; b[0] = '0;
        drive(1'b1, 1'b1, k, a, b);
        idle(5);

        // Burst of 6 with a 2-cycle stall after the 2nd; stalled inputs must be ignored
        for (int i = 0; i < 8; i++) begin
            for (int l = 0; l < NL; l++) begin
                k[l] = 2'($urandom); a[l] = rnd_val(); b[l] = rnd_val();
            end
            drive(1'b1, !(i == 2 || i == 3), k, a, b);
        end
        idle(5);

        // Mid-stream asynchronous reset with two samples in flight
        for (int i = 0; i < 2; i++) begin
            for (int l = 0; l < NL; l++) begin
                k[l] = 2'($urandom); a[l] = rnd_val(); b[l] = rnd_val();
            end
            drive(1'b1, 1'b1, k, a, b);
        end
        #2 rst_n = 1'b0; i_valid = 1'b0;
        #1;
        chk("async_rst_valid", o_valid, 0);
        chk("async_rst_re", |o_re, 0);
        chk("async_rst_im", |o_im, 0);
        sb.delete();
        @(negedge clk); #2 rst_n = 1'b1;
        k = '0; a = '0; b = '0;
        k[2] = 2'd1; a[2] = NBI'(-7); b[2] = NBI'(11);
        drive(1'b1, 1'b1, k, a, b);
        idle(5);

        // Random traffic with bubbles and stalls
        for (int i = 0; i < 2000; i++) begin
            v = ($urandom_range(0, 3) != 0);
            e = ($urandom_range(0, 7) != 0);
            for (int l = 0; l < NL; l++) begin
                k[l] = 2'($urandom); a[l] = rnd_val(); b[l] = rnd_val();
            end
            drive(v, e, k, a, b);
        end
        idle(6);
        chk("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/csd_twiddle_mult.md
CSD_TWIDDLE_MULT -- requirements
Module: csd_twiddle_mult

Interface
REQ-001 SHALL have parameter NB_INPUT, default 23, signed width of each input real/imag component.
REQ-002 SHALL have parameter NB_OUTPUT, default NB_INPUT+11, signed width of each output component; other values unsupported.
REQ-003 SHALL have parameter N_LANES, default 4, number of independent parallel complex lanes.
REQ-004 SHALL have port clk, input, 1, single clock; all registers update on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port i_en, input, 1, pipeline advance enable.
REQ-007 SHALL have port i_valid, input, 1, marks the input vector as a sample.
REQ-008 SHALL have port i_sel, input, 2*N_LANES, per-lane twiddle index k (lane n at bits [2n+1:2n]).
REQ-009 SHALL have port i_re, input, NB_INPUT*N_LANES, per-lane signed real part (lane n at the n-th slice from LSB).
REQ-010 SHALL have port i_im, input, NB_INPUT*N_LANES, per-lane signed imaginary part.
REQ-011 SHALL have port o_valid, output, 1, marks o_re/o_im as a result.
REQ-012 SHALL have port o_re, output, NB_OUTPUT*N_LANES, per-lane signed real result.
REQ-013 SHALL have port o_im, output, NB_OUTPUT*N_LANES, per-lane signed imaginary result.

Function
REQ-014 SHALL compute per lane y = x * W8^k with x = a + jb, a = i_re slice, b = i_im slice; C = 724 (1/sqrt2 scaled by 2^10).
REQ-015 SHALL produce, for k=0: re = a*1024, im = b*1024.
REQ-016 SHALL produce, for k=1: re = (a+b)*C, im = (b-a)*C.
REQ-017 SHALL produce, for k=2: re = b*1024, im = -a*1024.
REQ-018 SHALL produce, for k=3: re = (b-a)*C, im = -(a+b)*C.
REQ-019 SHALL compute the pre-add (a+b), (b-a) at NB_INPUT+1 bits with no truncation.
REQ-020 SHALL implement multiplication by C only as a CSD shift-add/subtract network, with no `*` operator and no generic multiplier.
REQ-021 SHALL compute full precision, sign-extended to NB_OUTPUT, with no rounding, saturation or overflow for any input including -2^(NB_INPUT-1).
REQ-022 SHALL be a 3-stage pipeline:
- S1 registers inputs, sel and valid.
- S2 registers the pre-add and operand mux.
- S3 registers the CSD result and output negation.
REQ-023 SHALL, when i_en=1, make the output appear exactly 3 rising edges after the input is sampled, with o_valid equal to i_valid delayed by 3 enabled cycles.
REQ-024 SHALL, when i_en=0, hold every pipeline register, including the valid chain and outputs, and ignore all inputs.
REQ-025 SHALL process every enabled cycle, with or without i_valid, producing throughput of 1 vector per enabled cycle and no backpressure.
REQ-026 SHALL keep lanes fully independent, each with its own k; i_sel travels with its data through the pipeline.
REQ-027 SHALL leave o_re/o_im as don't-care when o_valid=0, while still being deterministic from pipeline contents.

Reset
REQ-028 SHALL, on rst_n=0, immediately clear all pipeline registers, o_valid, o_re and o_im to 0, without waiting for clk.
REQ-029 SHALL discard all in-flight samples when reset is asserted mid-stream; the first o_valid=1 after release occurs 3 enabled cycles after the first valid input sampled post-release.
REQ-030 SHALL capture the first input on the first rising edge with rst_n=1 and i_en=1.

Verification (NB_INPUT=23, N_LANES=4)
REQ-031 SHALL pass this scenario:
- stimulus: lane0 a=100, b=0, k=1; i_valid=1; i_en=1.
- response: 3 cycles later, o_valid=1, lane0 re=72400, im=-72400.
REQ-032 SHALL pass this scenario:
- stimulus: lanes 0..3 a=5, b=-3, k=0,1,2,3 in one vector.
- response: re/im = (5120,-3072), (1448,-5792), (-3072,-5120), (-5792,-1448).
REQ-033 SHALL pass this scenario:
- stimulus: lane0 a=b=-4194304, k=3; then lane0 a=-4194304, b=0, k=2.
- response: first result re=0, im=6073352192; second result re=0, im=4294967296; no wrap.
REQ-034 SHALL pass this scenario:
- stimulus: valid burst of 6 vectors with i_en=0 for 2 cycles after the 2nd vector.
- response: all 6 results appear in order, o_valid stays held during the stall, and total latency is 3+2 cycles for stalled vectors.
REQ-035 SHALL pass this scenario:
- stimulus: rst_n pulsed low asynchronously between edges with 2 samples in flight.
- response: outputs 0 immediately, neither sample ever appears, and normal latency resumes after release.
REQ-036 SHALL pass this scenario:
- stimulus: 10^5 random a, b, k per lane, including extremes.
- response: every valid output bit-exact against the golden formula of REQ-015..018.
